// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches the combined push-button/DCM-lock reset, then releases NUM_OUT reset domains in order.
// Optional cause register is built when RSTSEQ_CAUSE_EN is defined; otherwise rst_cause_o is tied to 2'b00.
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_DELAY = 8
) (
   input  logic               clk_i,
   input  logic               resetn_i,
   input  logic               dcm_locked_i,
   input  logic               sw_rst_req_i,
   output logic [NUM_OUT-1:0] rstn_o,
   output logic               rst_done_o,
   output logic [1:0]         rst_cause_o
);

   localparam int MAX_DLY = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
   localparam int CNT_W   = $clog2(MAX_DLY + 1);
   localparam int K_W     = $clog2(NUM_OUT + 1);

   localparam logic [CNT_W-1:0] CNT_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
   localparam logic [K_W-1:0]   K_LAST         = K_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [SYNC_STAGES-1:0] r_lock_sync;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [K_W-1:0]         r_k;
   logic [K_W-1:0]         w_k_nxt;
   logic [NUM_OUT-1:0]     r_rstn;
   logic [NUM_OUT-1:0]     w_rstn_nxt;
   logic                   r_done;
   logic                   w_done_nxt;
   logic                   w_rst_sync;
   logic                   w_lock_s;
   logic                   w_lock_loss;
   logic                   w_sw_rst;

   // Release synchroniser for resetn_i and lock synchroniser for dcm_locked_i
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_rst_sync  <= {SYNC_STAGES{1'b0}};
         r_lock_sync <= {SYNC_STAGES{1'b0}};
      end else begin
         r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], dcm_locked_i};
      end
   end

   assign w_rst_sync  = r_rst_sync[SYNC_STAGES-1];
   assign w_lock_s    = r_lock_sync[SYNC_STAGES-1];
   // Lock loss outranks a software request arriving in the same cycle
   assign w_lock_loss = (r_state != ST_WAIT_LOCK) && !w_lock_s;
   assign w_sw_rst    = (r_state == ST_RUN) && w_lock_s && sw_rst_req_i;

   // Next-state and next-output logic of the sequencing FSM
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_k_nxt     = r_k;
      w_rstn_nxt  = r_rstn;
      w_done_nxt  = r_done;
      if (w_lock_loss || w_sw_rst) begin
         w_state_nxt = w_lock_loss ? ST_WAIT_LOCK : ST_HOLD;
         w_cnt_nxt   = {CNT_W{1'b0}};
         w_k_nxt     = {K_W{1'b0}};
         w_rstn_nxt  = {NUM_OUT{1'b0}};
         w_done_nxt  = 1'b0;
      end else begin
         case (r_state)
            ST_WAIT_LOCK: begin
               w_cnt_nxt  = {CNT_W{1'b0}};
               w_k_nxt    = {K_W{1'b0}};
               w_rstn_nxt = {NUM_OUT{1'b0}};
               w_done_nxt = 1'b0;
               if (w_rst_sync && w_lock_s) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_WAIT_LOCK;
               end
            end
            ST_HOLD: begin
               if (r_cnt == CNT_HOLD_LAST) begin
                  w_rstn_nxt[0] = 1'b1;
                  w_cnt_nxt     = {CNT_W{1'b0}};
                  w_k_nxt       = K_W'(1);
                  if (NUM_OUT == 1) begin
                     w_state_nxt = ST_RUN;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = ST_RELEASE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (r_cnt == CNT_STAGE_LAST) begin
                  for (int i = 0; i < NUM_OUT; i++) begin
                     if (r_k == K_W'(i)) begin
                        w_rstn_nxt[i] = 1'b1;
                     end else begin
                        w_rstn_nxt[i] = r_rstn[i];
                     end
                  end
                  w_cnt_nxt = {CNT_W{1'b0}};
                  w_k_nxt   = r_k + K_W'(1);
                  if (r_k == K_LAST) begin
                     w_state_nxt = ST_RUN;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = ST_RELEASE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = {CNT_W{1'b0}};
               w_k_nxt     = {K_W{1'b0}};
               w_rstn_nxt  = {NUM_OUT{1'b0}};
               w_done_nxt  = 1'b0;
            end
         endcase
      end
   end

   // FSM state, counters and registered outputs
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state <= ST_WAIT_LOCK;
         r_cnt   <= {CNT_W{1'b0}};
         r_k     <= {K_W{1'b0}};
         r_rstn  <= {NUM_OUT{1'b0}};
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_k     <= w_k_nxt;
         r_rstn  <= w_rstn_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign rstn_o     = r_rstn;
   assign rst_done_o = r_done;

`ifdef RSTSEQ_CAUSE_EN
   logic [1:0] r_cause;

   // Cause of the most recent reset; only resetn_i returns it to 00
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_cause <= 2'b00;
      end else if (w_lock_loss) begin
         r_cause <= 2'b01;
      end else if (w_sw_rst) begin
         r_cause <= 2'b10;
      end else begin
         r_cause <= r_cause;
      end
   end

   assign rst_cause_o = r_cause;
`else
   assign rst_cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a cycle-level model predicts every output change, a monitor checks them.
module tb_reset_sequencer;

   localparam int NUM  = 3;
   localparam int HOLD = 8;
   localparam int STG  = 4;

   logic           clk    = 1'b0;
   logic           resetn = 1'b1;
   logic           lock   = 1'b1;
   logic           sw     = 1'b0;
   logic [NUM-1:0] rstn;
   logic           done;
   logic [1:0]     cause;

   reset_sequencer #(
      .SYNC_STAGES(2),
      .NUM_OUT(NUM),
      .HOLD_CYCLES(HOLD),
      .STAGE_DELAY(STG)
   ) dut (
      .clk_i(clk),
      .resetn_i(resetn),
      .dcm_locked_i(lock),
      .sw_rst_req_i(sw),
      .rstn_o(rstn),
      .rst_done_o(done),
      .rst_cause_o(cause)
   );

   always #5 clk = ~clk;

   // Expected output word is {rstn, done, cause}, tagged with the cycle it must appear in
   typedef struct {
      int         cyc;
      logic [5:0] val;
   } ev_t;

   ev_t  q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: sequencing expressed as "start-of-hold cycle" plus arithmetic on elapsed time
   bit         in_reset = 1'b1;
   int         rel_cyc  = 0;
   bit         active   = 1'b0;
   int         hs       = 0;
   logic [1:0] m_cause  = 2'b00;
   logic [5:0] last_exp = 6'b0;
   bit         lock_hist [0:65535];

   task automatic set_cause(input logic [1:0] v);
`ifdef RSTSEQ_CAUSE_EN
      m_cause = v;
`else
      m_cause = 2'b00;
`endif
   endtask

   function automatic logic [5:0] exp_at(input int c);
      int n;
      logic [NUM-1:0] r;
      if (!active) return {{NUM{1'b0}}, 1'b0, m_cause};
      if (c < hs + HOLD) n = 0;
      else n = (c - hs - HOLD) / STG + 1;
      if (n > NUM) n = NUM;
      r = NUM'((1 << n) - 1);
      return {r, (n == NUM), m_cause};
   endfunction

   // One clock cycle of stimulus; the model predicts the outputs of the following cycle
   task automatic step(input bit lk, input bit s, input bit rel);
      int c;
      bit lock_s, rst_ok, done_c;
      logic [5:0] e;
      @(negedge clk);
      c    = cyc;
      lock = lk;
      sw   = s;
      lock_hist[c] = lk;
      if (rel && in_reset) begin
         resetn   = 1'b1;
         in_reset = 1'b0;
         rel_cyc  = c;
      end
      rst_ok = !in_reset && (c >= rel_cyc + 2);
      lock_s = rst_ok && lock_hist[c-2];
      done_c = active && (c >= hs + HOLD + (NUM - 1) * STG);
      if (!in_reset) begin
         if (!active) begin
            if (rst_ok && lock_s) begin
               active = 1'b1;
               hs     = c + 1;
            end
         end else if (!lock_s) begin
            active = 1'b0;
            set_cause(2'b01);
         end else if (done_c && s) begin
            hs = c + 1;
            set_cause(2'b10);
         end
      end
      e = exp_at(c + 1);
      if (e != last_exp) begin
         q.push_back('{cyc: c + 1, val: e});
         last_exp = e;
      end
   endtask

   // Assert resetn mid-cycle; outputs must clear without any clock edge
   task automatic async_reset();
      int c;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      c = cyc;
      while (q.size() > 0 && q[$].cyc >= c) void'(q.pop_back());
      in_reset = 1'b1;
      active   = 1'b0;
      m_cause  = 2'b00;
      if (last_exp != 6'b0) q.push_back('{cyc: c, val: 6'b0});
      last_exp = 6'b0;
      #1;
      n_tests++;
      if ({rstn, done, cause} !== 6'b0) begin
         n_fail++;
         $display("FAIL async_clear: got %b, want 000000", {rstn, done, cause});
      end
   endtask

   // Monitor: every output change must match the next predicted event, and none may be missed
   logic [5:0] mon_prev = 6'b0;
   logic [5:0] mon_cur;
   ev_t        mon_e;
   always @(negedge clk) begin
      mon_cur = {rstn, done, cause};
      if (mon_cur != mon_prev) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d: got %b, want %b", cyc, mon_cur, mon_prev);
         end else begin
            mon_e = q.pop_front();
            if (mon_e.val != mon_cur || mon_e.cyc != cyc) begin
               n_fail++;
               $display("FAIL event: got %b at cyc %0d, want %b at cyc %0d", mon_cur, cyc, mon_e.val, mon_e.cyc);
            end
         end
         mon_prev = mon_cur;
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missing_event: got %b at cyc %0d, want %b at cyc %0d", mon_cur, cyc, mon_e.val, mon_e.cyc);
      end
   end

   initial begin
      #1 resetn = 1'b0;
      #2;
      n_tests++;
      if ({rstn, done, cause} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b, want 000000", {rstn, done, cause});
      end

      // power-up with lock already present
      repeat (5) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // lock loss in RUN, then recovery
      repeat (10) step(1'b0, 1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // software reset, second pulse lands in HOLD and is ignored
      step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // software request in the very cycle synchronised lock falls
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // async reset while rstn=011
      step(1'b1, 1'b1, 1'b0);
      repeat (14) step(1'b1, 1'b0, 1'b0);
      async_reset();
      repeat (3) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // late lock after reset release
      async_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      repeat (50) step(1'b0, 1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0, 1'b0);

      // randomized mix of waits, software pulses and lock glitches
      repeat (40) begin
         case ($urandom_range(0, 3))
            0: repeat ($urandom_range(1, 30)) step(1'b1, 1'b0, 1'b0);
            1: begin
               step(1'b1, 1'b1, 1'b0);
               repeat ($urandom_range(1, 25)) step(1'b1, 1'b0, 1'b0);
            end
            2: begin
               repeat ($urandom_range(1, 12)) step(1'b0, 1'b0, 1'b0);
               repeat ($urandom_range(1, 25)) step(1'b1, 1'b0, 1'b0);
            end
            default: begin
               step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
               repeat ($urandom_range(1, 25)) step(1'b1, 1'b0, 1'b0);
            end
         endcase
      end
      repeat (40) step(1'b1, 1'b0, 1'b0);

      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_events: got %0d left, want 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
